// File: rtl/i2s_rx_pkg.sv
// Shared encodings and types for the I2S microphone receiver.
package i2s_rx_pkg;

   localparam logic [1:0] CHAN_LEFT   = 2'b00;
   localparam logic [1:0] CHAN_RIGHT  = 2'b01;
   localparam logic [1:0] CHAN_STEREO = 2'b10;

   localparam logic CH_L = 1'b0;
   localparam logic CH_R = 1'b1;

   // Entry layout at the default output width; the FIFO stores {chan, data} in this order.
   localparam int ENTRY_DATA_BITS = 16;
   typedef struct packed {
      logic                       chan;
      logic [ENTRY_DATA_BITS-1:0] data;
   } fifo_entry_t;

   // Mode 2'b11 is reserved and behaves as stereo.
   function automatic logic chan_selected(input logic [1:0] mode, input logic chan);
      case (mode)
         CHAN_LEFT:   return chan == CH_L;
         CHAN_RIGHT:  return chan == CH_R;
         CHAN_STEREO: return 1'b1;
         default:     return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample FIFO with combinational head and drop-on-full overrun flag.
module i2s_sample_fifo
   import i2s_rx_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head,
   output logic             overrun
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop && !empty;
      // A pop in the same cycle frees the slot the push lands in.
      do_push  = push && (!full || do_pop);
      overrun  = push && full && !do_pop;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
   end

   assign head = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/i2s_rx_stream.sv
// I2S master receiver: bclk/lrclk generation, MSB-first capture, channel select, output FIFO.
// Optional overrun_count port when I2S_OVERRUN_CNT_EN is defined.
module i2s_rx_stream
   import i2s_rx_pkg::*;
#(
   parameter int CLK_DIV_HALF = 50,
   parameter int SLOT_BITS    = 32,
   parameter int SAMPLE_BITS  = 24,
   parameter int OUT_BITS     = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [1:0]          chan_mode,
   input  logic                sd,
   output logic                bclk,
   output logic                lrclk,
   output logic [OUT_BITS-1:0] sample_data,
   output logic                sample_chan,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                overrun
`ifdef I2S_OVERRUN_CNT_EN
   ,
   output logic [15:0]         overrun_count
`endif
);

   localparam int DIV_W = $clog2(CLK_DIV_HALF);
   localparam int IDX_W = $clog2(SLOT_BITS);
   localparam int SH_W  = SAMPLE_BITS - 1;
   localparam int ENT_W = OUT_BITS + 1;

   logic [DIV_W-1:0]    div_q, div_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [SH_W-1:0]     shift_q, shift_d;
   logic                bclk_q, bclk_d;
   logic                lrclk_q, lrclk_d;
   logic                startup_q, startup_d;
   logic                terminal, rise_evt, fall_evt, push_req;
   logic [OUT_BITS-1:0] cap_data;
   logic [ENT_W-1:0]    fifo_head;
   logic                fifo_empty, fifo_full_unused;

   // The final sd bit only matters when no truncation happens.
   generate
      if (OUT_BITS == SAMPLE_BITS) begin : g_full_width
         assign cap_data = {shift_q, sd};
      end else begin : g_truncate
         assign cap_data = shift_q[SH_W-1 -: OUT_BITS];
      end
   endgenerate

   always_comb begin
      div_d     = div_q;
      bclk_d    = bclk_q;
      lrclk_d   = lrclk_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      startup_d = startup_q;
      terminal  = (div_q == DIV_W'(CLK_DIV_HALF - 1));
      rise_evt  = en && terminal && !bclk_q;
      fall_evt  = en && terminal && bclk_q;
      push_req  = 1'b0;
      if (!en) begin
         div_d     = '0;
         bclk_d    = 1'b0;
         lrclk_d   = 1'b1;
         idx_d     = '0;
         shift_d   = '0;
         startup_d = 1'b1;
      end else begin
         div_d = terminal ? '0 : div_q + 1'b1;
         if (terminal) bclk_d = !bclk_q;
         if (rise_evt) begin
            idx_d = (idx_q == IDX_W'(SLOT_BITS - 1)) ? '0 : idx_q + 1'b1;
            // Index 0 is the I2S delay bit; bits past the sample are padding.
            if (idx_q != '0 && idx_q <= IDX_W'(SAMPLE_BITS))
               shift_d = {shift_q[SH_W-2:0], sd};
            if (idx_q == IDX_W'(SAMPLE_BITS))
               push_req = chan_selected(chan_mode, lrclk_q) && !startup_q;
         end
         // idx wraps to 0 only after the last rise of a slot, so this fall ends the slot.
         if (fall_evt && idx_q == '0) begin
            lrclk_d   = !lrclk_q;
            startup_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q     <= '0;
         bclk_q    <= 1'b0;
         lrclk_q   <= 1'b1;
         idx_q     <= '0;
         shift_q   <= '0;
         startup_q <= 1'b1;
      end else begin
         div_q     <= div_d;
         bclk_q    <= bclk_d;
         lrclk_q   <= lrclk_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         startup_q <= startup_d;
      end
   end

   i2s_sample_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req),
      .push_data ({lrclk_q, cap_data}),
      .pop       (sample_ready),
      .full      (fifo_full_unused),
      .empty     (fifo_empty),
      .head      (fifo_head),
      .overrun   (overrun)
   );

   assign bclk         = bclk_q;
   assign lrclk        = lrclk_q;
   assign sample_valid = !fifo_empty;
   assign sample_data  = sample_valid ? fifo_head[OUT_BITS-1:0] : '0;
   assign sample_chan  = sample_valid ? fifo_head[OUT_BITS] : CH_L;

`ifdef I2S_OVERRUN_CNT_EN
   logic [15:0] ovr_cnt_q, ovr_cnt_d;

   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (overrun && ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) ovr_cnt_q <= '0;
      else     ovr_cnt_q <= ovr_cnt_d;
   end

   assign overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_stream.sv
// Directed bench for i2s_rx_stream with a behavioural I2S microphone.
module tb_i2s_rx_stream;

   localparam logic [23:0] L_WORD = 24'h123456;
   localparam logic [23:0] R_WORD = 24'hFEDCBA;
   localparam logic [15:0] L_OUT  = 16'h1234;
   localparam logic [15:0] R_OUT  = 16'hFEDC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic [1:0]  chan_mode = 2'b10;
   logic        sd = 1'b0;
   logic        sample_ready = 1'b1;
   logic        bclk, lrclk, sample_chan, sample_valid, overrun;
   logic [15:0] sample_data;
`ifdef I2S_OVERRUN_CNT_EN
   logic [15:0] overrun_count;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic        chan;
      logic [15:0] data;
      int          t;
   } rec_t;
   rec_t mon_q[$];

   i2s_rx_stream dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .chan_mode    (chan_mode),
      .sd           (sd),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sample_data  (sample_data),
      .sample_chan  (sample_chan),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun)
`ifdef I2S_OVERRUN_CNT_EN
      ,
      .overrun_count(overrun_count)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Microphone: MSB one bclk after the word-select change, data changes on falling bclk.
   int          mic_cnt = 0;
   logic        mic_ws = 1'b1;
   logic [23:0] mic_word;
   always @(negedge bclk) begin
      if (lrclk !== mic_ws) begin
         mic_cnt = 0;
         mic_ws  = lrclk;
      end else begin
         mic_cnt = mic_cnt + 1;
      end
      mic_word = lrclk ? R_WORD : L_WORD;
      sd = (mic_cnt >= 1 && mic_cnt <= 24) ? mic_word[24 - mic_cnt] : 1'b0;
   end

   // Every accepted sample, stamped with the posedge count when it was popped-ready.
   always @(negedge clk) begin
      #1;
      if (sample_valid && sample_ready) begin
         mon_q.push_back('{chan: sample_chan, data: sample_data, t: cyc});
         $display("sample t=%0d chan=%0d data=%h", cyc, sample_chan, sample_data);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // sel: 0 bclk, 1 lrclk, 2 sample_valid, 3 overrun
   task automatic wait_sig(input string tag, input int sel, input logic level,
                           input int max_cyc, output int t);
      bit hit;
      hit = 1'b0;
      t = -1;
      for (int i = 0; i < max_cyc && !hit; i++) begin
         @(negedge clk);
         case (sel)
            0:       hit = (bclk === level);
            1:       hit = (lrclk === level);
            2:       hit = (sample_valid === level);
            default: hit = (overrun === level);
         endcase
      end
      if (hit) t = cyc;
      chk({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic wait_samples(input string tag, input int n, input int max_cyc);
      for (int i = 0; i < max_cyc && mon_q.size() < n; i++) @(negedge clk);
      chk({tag, "_count"}, 32'(mon_q.size()), 32'(n));
   endtask

   task automatic chk_rec(input string tag, input int k, input logic ch, input logic [15:0] d);
      rec_t r;
      r = '{chan: 1'b0, data: 16'h0, t: 0};
      if (k < mon_q.size()) r = mon_q[k];
      chk({tag, "_chan"}, 32'(r.chan), 32'(ch));
      chk({tag, "_data"}, 32'(r.data), 32'(d));
   endtask

   initial begin
      int c0, t1, t2, t3, t4, t, t_o;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_bclk", 32'(bclk), 32'd0);
      chk("rst_lrclk", 32'(lrclk), 32'd1);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_data", 32'(sample_data), 32'd0);
      chk("rst_chan", 32'(sample_chan), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
`ifdef I2S_OVERRUN_CNT_EN
      chk("rst_ovr_cnt", 32'(overrun_count), 32'd0);
`endif
      c0 = cyc;
      rst = 1'b0;

      // Clock generation and stereo stream
      wait_sig("bclk_rise1", 0, 1'b1, 200, t1);
      wait_sig("bclk_fall", 0, 1'b0, 200, t);
      wait_sig("bclk_rise2", 0, 1'b1, 200, t2);
      chk("bclk_first_rise", 32'(t1 - c0), 32'd50);
      chk("bclk_period", 32'(t2 - t1), 32'd100);
      wait_sig("lr_fall1", 1, 1'b0, 4000, t3);
      wait_sig("lr_rise", 1, 1'b1, 4000, t);
      wait_sig("lr_fall2", 1, 1'b0, 4000, t4);
      chk("lrclk_first_toggle", 32'(t3 - c0), 32'd3200);
      chk("lrclk_period", 32'(t4 - t3), 32'd6400);
      wait_samples("stereo", 4, 8000);
      chk_rec("stereo0", 0, 1'b0, L_OUT);
      chk_rec("stereo1", 1, 1'b1, R_OUT);
      chk_rec("stereo2", 2, 1'b0, L_OUT);
      chk_rec("stereo3", 3, 1'b1, R_OUT);
      if (mon_q.size() > 0) chk("first_latency", 32'(mon_q[0].t - c0), 32'd5650);

      // Left only
      chan_mode = 2'b00;
      mon_q.delete();
      wait_samples("left", 2, 14000);
      chk_rec("left0", 0, 1'b0, L_OUT);
      chk_rec("left1", 1, 1'b0, L_OUT);
      if (mon_q.size() > 1) chk("left_gap", 32'(mon_q[1].t - mon_q[0].t), 32'd6400);

      // Right only
      chan_mode = 2'b01;
      mon_q.delete();
      wait_samples("right", 1, 8000);
      chk_rec("right0", 0, 1'b1, R_OUT);

      // en dropped mid-slot with two samples buffered
      chan_mode = 2'b10;
      sample_ready = 1'b0;
      mon_q.delete();
      wait_sig("en_fill", 2, 1'b1, 4000, t);
      repeat (4900) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("en_low_bclk", 32'(bclk), 32'd0);
      chk("en_low_lrclk", 32'(lrclk), 32'd1);
      sample_ready = 1'b1;
      repeat (3000) @(negedge clk);
      chk("en_low_bclk_late", 32'(bclk), 32'd0);
      chk("en_low_lrclk_late", 32'(lrclk), 32'd1);
      chk("en_drain_count", 32'(mon_q.size()), 32'd2);
      chk_rec("en_drain0", 0, 1'b0, L_OUT);
      chk_rec("en_drain1", 1, 1'b1, R_OUT);
      chk("en_drain_empty", 32'(sample_valid), 32'd0);
      mon_q.delete();
      c0 = cyc;
      en = 1'b1;
      wait_samples("en_restart", 1, 7000);
      chk_rec("en_restart0", 0, 1'b0, L_OUT);
      if (mon_q.size() > 0) chk("en_restart_latency", 32'(mon_q[0].t - c0), 32'd5650);

      // Reset with three entries held, then fill to overrun
      sample_ready = 1'b0;
      mon_q.delete();
      repeat (9700) @(negedge clk);
      chk("pre_rst_valid", 32'(sample_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 32'(sample_valid), 32'd0);
      chk("mid_rst_bclk", 32'(bclk), 32'd0);
      chk("mid_rst_lrclk", 32'(lrclk), 32'd1);
      chk("mid_rst_data", 32'(sample_data), 32'd0);
      c0 = cyc;
      rst = 1'b0;
      wait_sig("post_rst_valid", 2, 1'b1, 6000, t);
      chk("post_rst_latency", 32'(t - c0), 32'd5650);
      chk("post_rst_head_chan", 32'(sample_chan), 32'd0);
      chk("post_rst_head_data", 32'(sample_data), 32'(L_OUT));
      wait_sig("ovr", 3, 1'b1, 14000, t_o);
      chk("ovr_time", 32'(t_o - c0), 32'd18449);
      @(negedge clk);
      chk("ovr_pulse_width", 32'(overrun), 32'd0);
`ifdef I2S_OVERRUN_CNT_EN
      chk("ovr_cnt_one", 32'(overrun_count), 32'd1);
`endif
      chk("full_head_data", 32'(sample_data), 32'(L_OUT));

      // Pop exactly on the next completion cycle
      repeat (3199) @(negedge clk);
      sample_ready = 1'b1;
      #1;
      chk("simul_no_ovr", 32'(overrun), 32'd0);
      chk("simul_valid", 32'(sample_valid), 32'd1);
      @(negedge clk);
      sample_ready = 1'b0;
      @(negedge clk);
      sample_ready = 1'b1;
      wait_samples("final_drain", 5, 20);
      chk_rec("final0", 0, 1'b0, L_OUT);
      chk_rec("final1", 1, 1'b1, R_OUT);
      chk_rec("final2", 2, 1'b0, L_OUT);
      chk_rec("final3", 3, 1'b1, R_OUT);
      chk_rec("final4", 4, 1'b1, R_OUT);
`ifdef I2S_OVERRUN_CNT_EN
      chk("ovr_cnt_final", 32'(overrun_count), 32'd1);
`endif
      repeat (5) @(negedge clk);
      chk("final_empty", 32'(sample_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
